// File: rtl/ci_scratchpad_dma.sv
// Custom-instruction scratchpad RAM with an internal block-copy engine.
// The CPU side answers one CI at a time. The copy engine moves one word per
// cycle through a read-then-write pipeline and gives way to CPU RAM accesses.
module ci_scratchpad_dma #(
    parameter logic [7:0]  customId   = 8'h00,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic [31:0] result,
    output logic        done
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   L_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0] A_ONE   = 1;

    typedef enum logic [2:0] {
        OP_READ = 3'd0, OP_WRITE = 3'd1, OP_SET_SRC = 3'd2, OP_SET_DST = 3'd3,
        OP_COPY = 3'd4, OP_STATUS = 3'd5, OP_WAIT = 3'd6, OP_ILLEGAL = 3'd7
    } op_t;
    typedef enum logic [1:0] {CI_IDLE, CI_RD_ISSUE, CI_RD_OUT, CI_WAIT_COPY} ci_state_t;
    typedef enum logic {C_IDLE, C_RUN} cp_state_t;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_q, hold_data, status_word, result_n, result_r;
    ci_state_t ci_state, ci_next;
    cp_state_t cp_state, cp_next;
    op_t op;
    logic req, illegal, busy, stall, cpu_we, cpu_rd, set_src, set_dst, copy_go;
    logic done_n, done_r, cp_issue, cp_write, wv, hold;
    logic mem_we, mem_re;
    logic [ADDR_WIDTH-1:0] a_addr, rd_addr, src, dst, rptr, wptr, mem_waddr, mem_raddr;
    logic [ADDR_WIDTH:0]   len_req, len_clamped, iss_left, count;
    logic [31:0] mem_wdata;
    logic unused_bits;

    assign unused_bits = ^{valueA, valueB};
    assign op          = op_t'(valueA[12:10]);
    assign illegal     = (op == OP_ILLEGAL) || (|valueA[31:13]);
    assign a_addr      = valueA[ADDR_WIDTH-1:0];
    assign req         = start && (ciN == customId) && (ci_state == CI_IDLE);
    assign busy        = (cp_state == C_RUN);
    assign len_req     = valueB[ADDR_WIDTH:0];
    assign len_clamped = (len_req > DEPTH_L) ? DEPTH_L : len_req;
    assign cpu_rd      = (ci_state == CI_RD_ISSUE);
    assign stall       = cpu_we || cpu_rd;

    // Status word: busy flag on top, words still to be written at the bottom
    always_comb begin
        status_word = '0;
        status_word[31] = busy;
        status_word[ADDR_WIDTH:0] = count;
    end

    // CI request decode and next-state
    always_comb begin
        ci_next  = ci_state;
        done_n   = 1'b0;
        result_n = '0;
        cpu_we   = 1'b0;
        set_src  = 1'b0;
        set_dst  = 1'b0;
        copy_go  = 1'b0;
        case (ci_state)
            CI_IDLE: if (req) begin
                if (illegal) begin
                    done_n   = 1'b1;
                    result_n = '1;
                end else begin
                    case (op)
                        OP_READ:    ci_next = CI_RD_ISSUE;
                        OP_WRITE:   begin cpu_we = 1'b1; done_n = 1'b1; end
                        OP_SET_SRC: begin done_n = 1'b1; if (busy) result_n = 32'd1; else set_src = 1'b1; end
                        OP_SET_DST: begin done_n = 1'b1; if (busy) result_n = 32'd1; else set_dst = 1'b1; end
                        OP_COPY: begin
                            done_n = 1'b1;
                            if (busy) result_n = 32'd1;
                            else if (len_clamped != '0) copy_go = 1'b1;
                        end
                        OP_STATUS:  begin done_n = 1'b1; result_n = status_word; end
                        OP_WAIT:    if (busy) ci_next = CI_WAIT_COPY; else done_n = 1'b1;
                        default:    ;
                    endcase
                end
            end
            CI_RD_ISSUE:  ci_next = CI_RD_OUT;
            CI_RD_OUT:    ci_next = CI_IDLE;
            CI_WAIT_COPY: if (!busy) ci_next = CI_IDLE;
            default:      ci_next = CI_IDLE;
        endcase
    end

    // CI state and registered response
    always_ff @(posedge clock) begin
        if (reset) begin
            ci_state <= CI_IDLE;
            done_r   <= 1'b0;
            result_r <= '0;
            rd_addr  <= '0;
        end else begin
            ci_state <= ci_next;
            done_r   <= done_n;
            result_r <= result_n;
            if (req) rd_addr <= a_addr;
        end
    end

    // Completion: registered replies, read data, or copy-finished wakeup
    assign done = done_r || (ci_state == CI_RD_OUT) || (ci_state == CI_WAIT_COPY && !busy);

    // Result is zero unless done is high
    always_comb begin
        result = '0;
        if (done_r) result = result_r;
        else if (ci_state == CI_RD_OUT) result = rd_q;
    end

    // Copy engine next-state; any CPU port use freezes the whole pipeline
    always_comb begin
        cp_next  = cp_state;
        cp_issue = busy && !stall && (iss_left != '0);
        cp_write = wv && !stall;
        case (cp_state)
            C_IDLE:  if (copy_go) cp_next = C_RUN;
            C_RUN:   if (cp_write && count == L_ONE) cp_next = C_IDLE;
            default: cp_next = C_IDLE;
        endcase
    end

    // Copy engine registers. A word already read when a stall hits is parked in
    // hold_data, since a CPU read in the same cycle overwrites rd_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            cp_state <= C_IDLE;
            src      <= '0;
            dst      <= '0;
            rptr     <= '0;
            wptr     <= '0;
            iss_left <= '0;
            count    <= '0;
            wv       <= 1'b0;
            hold     <= 1'b0;
        end else begin
            cp_state <= cp_next;
            if (set_src) src <= valueB[ADDR_WIDTH-1:0];
            if (set_dst) dst <= valueB[ADDR_WIDTH-1:0];
            if (copy_go) begin
                rptr     <= src;
                wptr     <= dst;
                iss_left <= len_clamped;
                count    <= len_clamped;
                wv       <= 1'b0;
                hold     <= 1'b0;
            end else begin
                if (cp_issue) begin
                    rptr     <= rptr + A_ONE;
                    iss_left <= iss_left - L_ONE;
                end
                if (!stall) wv <= cp_issue;
                if (cp_write) begin
                    wptr  <= wptr + A_ONE;
                    count <= count - L_ONE;
                    hold  <= 1'b0;
                end else if (stall && wv && !hold) begin
                    hold      <= 1'b1;
                    hold_data <= rd_q;
                end
            end
        end
    end

    assign mem_we    = cpu_we || cp_write;
    assign mem_waddr = cpu_we ? a_addr : wptr;
    assign mem_wdata = cpu_we ? valueB : (hold ? hold_data : rd_q);
    assign mem_re    = cpu_rd || cp_issue;
    assign mem_raddr = cpu_rd ? rd_addr : rptr;

    // Synchronous RAM, one write and one read port, contents survive reset
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (mem_re) rd_q <= mem[mem_raddr];
    end
endmodule

// File: tb/tb_ci_scratchpad_dma.sv
// Directed bench for ci_scratchpad_dma: handshake latency, illegal requests,
// block copies (including address wrap), busy behaviour and reset mid-copy.
module tb_ci_scratchpad_dma;
    logic        clock, reset, start, done;
    logic [7:0]  ciN;
    logic [31:0] valueA, valueB, result;
    int passed = 0;
    int total  = 0;

    ci_scratchpad_dma #(.customId(8'h00), .ADDR_WIDTH(9)) dut (
        .clock(clock), .reset(reset), .start(start), .ciN(ciN),
        .valueA(valueA), .valueB(valueB), .result(result), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [2:0] op, input logic [9:0] addr);
        return {19'd0, op, addr};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one CI, wait (bounded) for done; lat = cycles from start, -1 on timeout
    task automatic ci_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat);
        ciN = 8'h00; valueA = a; valueB = b; start = 1'b1;
        tick();
        start = 1'b0; valueA = '0; valueB = '0;
        lat = 1;
        while (done !== 1'b1 && lat < 3000) begin
            tick();
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        r = result;
        tick();
    endtask

    initial begin
        logic [31:0] r;
        int lat;
        logic seen;
        reset = 1'b1; start = 1'b0; ciN = 8'h00; valueA = '0; valueB = '0;
        repeat (3) tick();
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        reset = 1'b0;
        tick();

        // Basic write / read
        ci_op(mk(3'd1, 10'd5), 32'hDEAD_BEEF, r, lat);
        chk("wr_lat", 32'(lat), 32'd1);
        ci_op(mk(3'd0, 10'd5), 32'd0, r, lat);
        chk("rd_lat", 32'(lat), 32'd2);
        chk("rd_data", r, 32'hDEAD_BEEF);
        chk("idle_result", result, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);

        // Foreign ciN: ignored entirely
        ciN = 8'h01; valueA = mk(3'd1, 10'd5); valueB = 32'h1234_5678; start = 1'b1;
        tick();
        start = 1'b0; ciN = 8'h00;
        seen = 1'b0;
        repeat (5) begin
            if (done) seen = 1'b1;
            tick();
        end
        chk("foreign_nodone", {31'd0, seen}, 32'd0);

        // Illegal requests: nonzero upper bits, opcode 7
        ci_op(32'h0000_2000, 32'd0, r, lat);
        chk("ill_hi_lat", 32'(lat), 32'd1);
        chk("ill_hi_res", r, 32'hFFFF_FFFF);
        ci_op(32'h0000_2405, 32'h0BAD_0BAD, r, lat);
        chk("ill_wr_res", r, 32'hFFFF_FFFF);
        ci_op(mk(3'd7, 10'd5), 32'h0BAD_0BAD, r, lat);
        chk("ill_op7_lat", 32'(lat), 32'd1);
        chk("ill_op7_res", r, 32'hFFFF_FFFF);
        ci_op(mk(3'd0, 10'd5), 32'd0, r, lat);
        chk("ram_unchanged", r, 32'hDEAD_BEEF);

        // Simple copy 0..7 -> 16..23
        for (int i = 0; i < 8; i++) ci_op(mk(3'd1, 10'(i)), 32'(i + 1), r, lat);
        ci_op(mk(3'd2, 10'd0), 32'd0, r, lat);
        chk("setsrc_res", r, 32'd0);
        ci_op(mk(3'd3, 10'd0), 32'd16, r, lat);
        chk("setdst_res", r, 32'd0);
        ci_op(mk(3'd4, 10'd0), 32'd8, r, lat);
        chk("copy_lat", 32'(lat), 32'd1);
        chk("copy_res", r, 32'd0);
        ci_op(mk(3'd6, 10'd0), 32'd0, r, lat);
        chk("wait_lat", 32'(lat), 32'd8);
        chk("wait_res", r, 32'd0);
        for (int i = 0; i < 8; i++) begin
            ci_op(mk(3'd0, 10'(16 + i)), 32'd0, r, lat);
            chk($sformatf("copy1_rd%0d", i), r, 32'(i + 1));
        end

        // Source range wraps: 510,511,0,1 -> 100..103
        ci_op(mk(3'd1, 10'd510), 32'hA0, r, lat);
        ci_op(mk(3'd1, 10'd511), 32'hA1, r, lat);
        ci_op(mk(3'd1, 10'd0),   32'hA2, r, lat);
        ci_op(mk(3'd1, 10'd1),   32'hA3, r, lat);
        ci_op(mk(3'd2, 10'd0), 32'd510, r, lat);
        ci_op(mk(3'd3, 10'd0), 32'd100, r, lat);
        ci_op(mk(3'd4, 10'd0), 32'd4, r, lat);
        ci_op(mk(3'd6, 10'd0), 32'd0, r, lat);
        for (int i = 0; i < 4; i++) begin
            ci_op(mk(3'd0, 10'(100 + i)), 32'd0, r, lat);
            chk($sformatf("wrap_src_rd%0d", i), r, 32'hA0 + 32'(i));
        end
        // Destination range wraps: 100..103 -> 511,0,1,2
        ci_op(mk(3'd2, 10'd0), 32'd100, r, lat);
        ci_op(mk(3'd3, 10'd0), 32'd511, r, lat);
        ci_op(mk(3'd4, 10'd0), 32'd4, r, lat);
        ci_op(mk(3'd6, 10'd0), 32'd0, r, lat);
        ci_op(mk(3'd0, 10'd511), 32'd0, r, lat);
        chk("wrap_dst_511", r, 32'hA0);
        for (int i = 0; i < 3; i++) begin
            ci_op(mk(3'd0, 10'(i)), 32'd0, r, lat);
            chk($sformatf("wrap_dst_rd%0d", i), r, 32'hA1 + 32'(i));
        end
        ci_op(mk(3'd0, 10'd3), 32'd0, r, lat);
        chk("wrap_dst_untouched", r, 32'd4);

        // Busy behaviour with CPU traffic interleaved: 200..215 -> 300..315
        for (int i = 0; i < 16; i++) ci_op(mk(3'd1, 10'(200 + i)), 32'h1000 + 32'(i), r, lat);
        ci_op(mk(3'd2, 10'd0), 32'd200, r, lat);
        ci_op(mk(3'd3, 10'd0), 32'd300, r, lat);
        ci_op(mk(3'd4, 10'd0), 32'd16, r, lat);
        ci_op(mk(3'd4, 10'd0), 32'd4, r, lat);
        chk("copy_busy_res", r, 32'd1);
        ci_op(mk(3'd5, 10'd0), 32'd0, r, lat);
        chk("status_busy1", r, 32'h8000_000E);
        ci_op(mk(3'd5, 10'd0), 32'd0, r, lat);
        chk("status_busy2", r, 32'h8000_000C);
        ci_op(mk(3'd2, 10'd0), 32'd0, r, lat);
        chk("setsrc_busy_res", r, 32'd1);
        ci_op(mk(3'd0, 10'd5), 32'd0, r, lat);
        chk("rd_during_copy_lat", 32'(lat), 32'd2);
        chk("rd_during_copy", r, 32'd6);
        ci_op(mk(3'd1, 10'd50), 32'h55, r, lat);
        ci_op(mk(3'd6, 10'd0), 32'd0, r, lat);
        chk("wait2_done", {31'd0, lat > 0}, 32'd1);
        chk("wait2_res", r, 32'd0);
        for (int i = 0; i < 16; i++) begin
            ci_op(mk(3'd0, 10'(300 + i)), 32'd0, r, lat);
            chk($sformatf("copy3_rd%0d", i), r, 32'h1000 + 32'(i));
        end
        ci_op(mk(3'd0, 10'd50), 32'd0, r, lat);
        chk("wr_during_copy", r, 32'h55);
        ci_op(mk(3'd5, 10'd0), 32'd0, r, lat);
        chk("status_idle", r, 32'd0);

        // Reset in the middle of a copy 300..315 -> 400..415
        ci_op(mk(3'd2, 10'd0), 32'd300, r, lat);
        ci_op(mk(3'd3, 10'd0), 32'd400, r, lat);
        ci_op(mk(3'd4, 10'd0), 32'd16, r, lat);
        repeat (3) tick();
        reset = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            tick();
            if (done) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (3) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("rst_mid_nodone", {31'd0, seen}, 32'd0);
        ci_op(mk(3'd5, 10'd0), 32'd0, r, lat);
        chk("status_after_rst", r, 32'd0);
        ci_op(mk(3'd0, 10'd400), 32'd0, r, lat);
        chk("partial_copy_kept", r, 32'h1000);
        ci_op(mk(3'd4, 10'd0), 32'd2, r, lat);
        chk("copy_after_rst", r, 32'd0);
        ci_op(mk(3'd6, 10'd0), 32'd0, r, lat);
        chk("wait_after_rst", {31'd0, lat > 0}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
